countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Round countdown timer. It sits between the game logic FSM and the display.
//  A rising edge on time_f loads time_v seconds and starts a countdown at 1 Hz.
//  When the count reaches 0 it raises end_f back to the game logic.
//  It also gives the seconds remaining, as binary and BCD, to the 7-seg driver.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per second; sim uses 4; must be >= 2
//  PW             26          prescaler width; must hold TICKS_PER_SEC-1
// PORTS
//  clk       in   1  system clock; single clock domain
//  rst       in   1  asynchronous, active-high reset
//  time_f    in   1  start request from game logic; asynchronous to clk; rising edge = load
//  time_v    in   5  seconds to load (0..31); stable whenever time_f is high
//  stop      in   1  abort countdown (game left play state); asynchronous to clk
//  end_f     out  1  time expired; level signal; held until next load or rst
//  running   out  1  countdown active
//  sec_left  out  5  seconds remaining, binary
//  sec_tens  out  4  seconds remaining, BCD tens (0..3)
//  sec_ones  out  4  seconds remaining, BCD ones (0..9)
//  sec_tick  out  1  one-clk pulse on each second decrement
// BEHAVIOUR
//  Reset (async, active-high):
//   - all outputs 0, FSM = IDLE, prescaler 0, sync flops 0.
//  Input synchronisation:
//   - time_f passes through 2 flops (s1, s2) plus edge flop s3.
//   - load = s2 & ~s3.
//   - stop passes through 2 flops; the synchronised level is used.
//  Latency:
//   - time_f rises before clk edge 1 -> load acts on edge 3.
//   - running and sec_left are visible after edge 3.
//  FSM states: IDLE, RUN, DONE.
//   - running = (RUN); end_f = (DONE).
//  Load (any state):
//   - sec_left <= time_v, prescaler <= 0, sec_tick <= 0.
//   - time_v != 0 -> RUN.
//   - time_v == 0 -> DONE on the load edge; sec_left = 0.
//   - Load in RUN restarts the count from the new time_v and clears the prescaler.
//   - Load in DONE clears end_f.
//  RUN:
//   - prescaler counts 0..TICKS_PER_SEC-1, then wraps to 0.
//   - On wrap: sec_left -= 1 and sec_tick = 1 for that cycle.
//   - Wrap with sec_left == 1: sec_left <= 0 and FSM -> DONE on the same edge.
//  Stop in RUN:
//   - FSM -> IDLE; sec_left is frozen; prescaler <= 0; end_f stays 0.
//  Stop in IDLE or DONE: no effect (end_f is kept).
//  Load and stop active in the same cycle: load wins.
//  DONE:
//   - Holds until the next load; prescaler is idle; sec_left = 0.
//  Arithmetic and encoding:
//   - sec_left never underflows.
//   - BCD is combinational from sec_left: tens = sec_left/10, ones = sec_left%10.
//   - BCD is registered with sec_left, so it has the same timing.
//  Upstream contract:
//   - Game logic drops time_f between rounds; a held-high time_f gives no reload.
// TESTING  (TICKS_PER_SEC=4)
//  1. time_v=3, pulse time_f
//      -> running at edge 3
//      -> sec_left 3,2,1,0 with sec_tick every 4 clk
//      -> end_f=1 and running=0 exactly 12 clk after load; end_f stays high.
//  2. time_v=0, pulse time_f
//      -> end_f=1 on the load edge; running never asserts; sec_tick never pulses.
//  3. time_v=27
//      -> tens=2, ones=7
//      -> after 8 ticks: sec_left=19, tens=1, ones=9.
//  4. Run 10 s; after 5 ticks reload time_v=6
//      -> sec_left=6, prescaler restarts at 0, end_f stays 0
//      -> end_f 24 clk later.
//  5. Run 5 s; assert stop after 2 ticks
//      -> running=0, sec_left frozen at 3, no end_f
//      -> stop and load in the same cycle -> RUN with the new value.
//  6. Run 5 s, then assert rst mid-count
//      -> all outputs 0 immediately (async), before the next clk edge.
//  7. After end_f=1, pulse time_f with time_v=4 -> end_f drops on the load edge.

Source files
------------

// File: rtl/countdown_timer.sv
// Round countdown timer: a synchronised rising edge on time_f loads time_v seconds,
// counts down at one second per TICKS_PER_SEC clocks and raises end_f at zero.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PW            = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_f,
  input  logic [4:0] time_v,
  input  logic       stop,
  output logic       end_f,
  output logic       running,
  output logic [4:0] sec_left,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [1:0]    state, state_next;
  logic [PW-1:0] prescaler, presc_next;
  logic [4:0]    sec_next;
  logic [3:0]    tens_next, ones_next;
  logic          tick_next;

  logic time_s1, time_s2, time_s3;
  logic stop_s1, stop_s2;
  logic load;

  assign load    = time_s2 & ~time_s3;
  assign running = (state == RUN);
  assign end_f   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_s1 <= 1'b0;
      time_s2 <= 1'b0;
      time_s3 <= 1'b0;
      stop_s1 <= 1'b0;
      stop_s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a real shift chain; blocking
      // ones would collapse the three flops into one in a single edge.
      time_s1 <= time_f;
      time_s2 <= time_s1;
      time_s3 <= time_s2;
      stop_s1 <= stop;
      stop_s2 <= stop_s1;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_next = state;
    sec_next   = sec_left;
    presc_next = prescaler;
    tick_next  = 1'b0;
    if (load) begin
      sec_next   = time_v;
      presc_next = '0;
      state_next = (time_v != 5'd0) ? RUN : DONE;
    end else begin
      case (state)
        RUN: begin
          if (stop_s2) begin
            state_next = IDLE;
            presc_next = '0;
          end else if (prescaler == PRESC_MAX) begin
            presc_next = '0;
            tick_next  = 1'b1;
            // Reaching zero and expiring share one edge; also guards underflow.
            if (sec_left <= 5'd1) begin
              sec_next   = 5'd0;
              state_next = DONE;
            end else begin
              sec_next = sec_left - 5'd1;
            end
          end else begin
            presc_next = prescaler + PW'(1);
          end
        end
        DONE: begin
          sec_next   = 5'd0;
          presc_next = '0;
        end
        default: begin
          state_next = IDLE;
          presc_next = '0;
        end
      endcase
    end
  end

  // BCD is derived from the next count so the digits register alongside sec_left.
  always_comb begin
    if (sec_next >= 5'd30) begin
      tens_next = 4'd3;
      ones_next = 4'(sec_next - 5'd30);
    end else if (sec_next >= 5'd20) begin
      tens_next = 4'd2;
      ones_next = 4'(sec_next - 5'd20);
    end else if (sec_next >= 5'd10) begin
      tens_next = 4'd1;
      ones_next = 4'(sec_next - 5'd10);
    end else begin
      tens_next = 4'd0;
      ones_next = 4'(sec_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      sec_left  <= 5'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= presc_next;
      sec_left  <= sec_next;
      sec_tens  <= tens_next;
      sec_ones  <= ones_next;
      sec_tick  <= tick_next;
    end
  end

endmodule
